// File: rtl/mem_miss_arbiter_pkg.sv
// Shared types and constants for the cache-miss memory arbiter.
// Block geometry and the FSM state encoding live here.
package mem_miss_arbiter_pkg;

   localparam int ADDR_W      = 16;
   localparam int BLOCK_WORDS = 8;
   localparam int WORD_W      = $clog2(BLOCK_WORDS);
   localparam int CNT_W       = WORD_W + 1;
   localparam int OFFS_W      = $clog2(2 * BLOCK_WORDS);

   localparam logic [ADDR_W-1:0] OFFSET_MASK =
      ADDR_W'((1 << OFFS_W) - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL_I = 2'd1,
      FILL_D = 2'd2
   } state_t;

   function automatic logic [ADDR_W-1:0] block_base(
      input logic [ADDR_W-1:0] a
   );
      return a & ~OFFSET_MASK;
   endfunction

endpackage

// File: rtl/mem_miss_arbiter_fill_counter.sv
// Issue/receive word counters for one block fill.
// Flags whether issue is still running and the final return.
module fill_counter
   import mem_miss_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_issue_inc,
   input  logic              i_recv_inc,
   output logic [CNT_W-1:0]  o_issue_cnt,
   output logic [WORD_W-1:0] o_recv_word,
   output logic              o_issuing,
   output logic              o_last
);

   logic [CNT_W-1:0] r_issue_cnt;
   logic [CNT_W-1:0] r_recv_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
      end else if (i_clr) begin
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
      end else begin
         if (i_issue_inc)
            r_issue_cnt <= r_issue_cnt + 1'b1;
         if (i_recv_inc)
            r_recv_cnt <= r_recv_cnt + 1'b1;
      end
   end

   assign o_issue_cnt = r_issue_cnt;
   assign o_recv_word = r_recv_cnt[WORD_W-1:0];
   assign o_issuing   = r_issue_cnt < CNT_W'(BLOCK_WORDS);
   assign o_last      = r_recv_cnt == CNT_W'(BLOCK_WORDS - 1);

endmodule

// File: rtl/mem_miss_arbiter.sv
// Shares the main-memory port between I/D miss fills and
// write-through stores; streams fill returns into the caches.
module mem_miss_arbiter
   import mem_miss_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_miss_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_miss_addr,
   input  logic              d_wr_req,
   input  logic [ADDR_W-1:0] d_wr_addr,
   input  logic [15:0]       d_wr_data,
   output logic              d_wr_ack,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data_in,
   input  logic              mem_data_valid,
   input  logic [15:0]       mem_data_out,
   output logic [15:0]       fill_data,
   output logic [WORD_W-1:0] fill_word,
   output logic              i_fill_we,
   output logic              d_fill_we,
   output logic              i_fill_done,
   output logic              d_fill_done
);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] w_base_nxt;
   logic              w_load;
   logic              w_clr;
   logic              w_issue_inc;
   logic              w_recv_inc;
   logic [CNT_W-1:0]  w_issue_cnt;
   logic [WORD_W-1:0] w_recv_word;
   logic              w_issuing;
   logic              w_last;

   fill_counter u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (w_clr),
      .i_issue_inc (w_issue_inc),
      .i_recv_inc  (w_recv_inc),
      .o_issue_cnt (w_issue_cnt),
      .o_recv_word (w_recv_word),
      .o_issuing   (w_issuing),
      .o_last      (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_base  <= '0;
      end else begin
         r_state <= w_next;
         if (w_load)
            r_base <= w_base_nxt;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_base_nxt  = '0;
      w_load      = 1'b0;
      w_clr       = 1'b0;
      w_issue_inc = 1'b0;
      w_recv_inc  = 1'b0;
      d_wr_ack    = 1'b0;
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_data_in = '0;
      fill_data   = '0;
      fill_word   = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            // store strobe is combinational, so hold it off in reset
            if (d_wr_req && rst_n) begin
               mem_enable  = 1'b1;
               mem_wr      = 1'b1;
               mem_addr    = d_wr_addr;
               mem_data_in = d_wr_data;
               d_wr_ack    = 1'b1;
            end else if (d_miss) begin
               w_next     = FILL_D;
               w_load     = 1'b1;
               w_base_nxt = block_base(d_miss_addr);
            end else if (i_miss) begin
               w_next     = FILL_I;
               w_load     = 1'b1;
               w_base_nxt = block_base(i_miss_addr);
            end
         end
         FILL_I, FILL_D: begin
            if (w_issuing) begin
               mem_enable  = 1'b1;
               mem_addr    = r_base + ADDR_W'({w_issue_cnt, 1'b0});
               w_issue_inc = 1'b1;
            end
            if (mem_data_valid) begin
               fill_data  = mem_data_out;
               fill_word  = w_recv_word;
               w_recv_inc = 1'b1;
               if (r_state == FILL_I)
                  i_fill_we = 1'b1;
               else
                  d_fill_we = 1'b1;
               if (w_last) begin
                  i_fill_done = (r_state == FILL_I);
                  d_fill_done = (r_state == FILL_D);
                  w_clr       = 1'b1;
                  w_next      = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Scoreboard bench for mem_miss_arbiter with an in-order
// variable-latency memory model and self-dropping cache requests.
module tb_mem_miss_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_miss, d_miss, d_wr_req;
   logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic        d_wr_ack, mem_enable, mem_wr;
   logic [15:0] mem_addr, mem_data_in;
   logic        mem_data_valid;
   logic [15:0] mem_data_out;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done;

   mem_miss_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_miss         (i_miss),
      .i_miss_addr    (i_miss_addr),
      .d_miss         (d_miss),
      .d_miss_addr    (d_miss_addr),
      .d_wr_req       (d_wr_req),
      .d_wr_addr      (d_wr_addr),
      .d_wr_data      (d_wr_data),
      .d_wr_ack       (d_wr_ack),
      .mem_enable     (mem_enable),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .mem_data_valid (mem_data_valid),
      .mem_data_out   (mem_data_out),
      .fill_data      (fill_data),
      .fill_word      (fill_word),
      .i_fill_we      (i_fill_we),
      .d_fill_we      (d_fill_we),
      .i_fill_done    (i_fill_done),
      .d_fill_done    (d_fill_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } mexp_t;

   typedef struct {
      bit          d;
      int          word;
      logic [15:0] data;
      bit          done;
      int          cyc;
   } fexp_t;

   typedef struct {
      int          rdy;
      logic [15:0] data;
   } pend_t;

   mexp_t mq[$];
   fexp_t fq[$];
   pend_t pq[$];
   mexp_t me;
   fexp_t fe;

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int t0;
   int ml, mr;
   bit var_lat = 1'b0;
   int li = 0;
   int lat_tab[8] = '{2, 6, 3, 5, 2, 4, 6, 2};
   bit drop_i = 1'b0;
   bit drop_d = 1'b0;
   bit drop_w = 1'b0;

   wire [57:0] w_outs = {d_wr_ack, mem_enable, mem_wr, mem_addr,
                         mem_data_in, fill_data, fill_word,
                         i_fill_we, d_fill_we, i_fill_done,
                         d_fill_done};

   function automatic logic [15:0] memw(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h want %h at cycle %0d",
                  nm, a, e, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_fill(input bit d, input logic [15:0] base,
                            input int ti, input int td);
      for (int k = 0; k < 8; k++) begin
         mq.push_back('{1'b0, 16'(base + 16'(2 * k)), 16'h0,
                        (ti < 0) ? -1 : ti + k});
         fq.push_back('{d, k, memw(16'(base + 16'(2 * k))),
                        (k == 7), (td < 0) ? -1 : td + k});
      end
   endtask

   task automatic drain(input int n);
      int k;
      k = 0;
      while ((mq.size() + fq.size()) > 0 && k < n) begin
         step();
         k++;
      end
      chk("drain", 64'(mq.size() + fq.size()), 64'(0));
      mq.delete();
      fq.delete();
      step();
      step();
   endtask

   // cycle counter, memory return driver and cache request drop
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (drop_i) begin i_miss = 1'b0; drop_i = 1'b0; end
         if (drop_d) begin d_miss = 1'b0; drop_d = 1'b0; end
         if (drop_w) begin d_wr_req = 1'b0; drop_w = 1'b0; end
         mem_data_valid = 1'b0;
         mem_data_out   = 16'h0;
         if (pq.size() > 0 && pq[0].rdy <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data_out   = pq[0].data;
            void'(pq.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (mem_enable && !mem_wr) begin
         ml = var_lat ? lat_tab[li] : 4;
         if (var_lat) li = (li + 1) % 8;
         mr = cyc + ml;
         if (pq.size() > 0 && mr <= pq[$].rdy)
            mr = pq[$].rdy + 1;
         pq.push_back('{mr, memw(mem_addr)});
      end
      if (i_fill_done) drop_i = 1'b1;
      if (d_fill_done) drop_d = 1'b1;
      if (d_wr_ack)    drop_w = 1'b1;
   end

   always @(negedge clk) begin
      if (mem_enable) begin
         chk("mem_pending", 64'(mq.size() > 0), 64'(1));
         if (mq.size() > 0) begin
            me = mq.pop_front();
            chk("mem_req",
                64'({d_wr_ack, mem_wr, mem_addr,
                     mem_wr ? mem_data_in : 16'h0, 16'(cyc)}),
                64'({me.wr, me.wr, me.addr, me.data,
                     (me.cyc < 0) ? 16'(cyc) : 16'(me.cyc)}));
         end
      end
      if (i_fill_we || d_fill_we || i_fill_done || d_fill_done) begin
         chk("fill_pending", 64'(fq.size() > 0), 64'(1));
         if (fq.size() > 0) begin
            fe = fq.pop_front();
            chk("fill",
                64'({i_fill_we, d_fill_we, i_fill_done, d_fill_done,
                     fill_word, fill_data, 16'(cyc)}),
                64'({~fe.d, fe.d, fe.done & ~fe.d, fe.done & fe.d,
                     3'(fe.word), fe.data,
                     (fe.cyc < 0) ? 16'(cyc) : 16'(fe.cyc)}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
      i_miss_addr = '0; d_miss_addr = '0;
      d_wr_addr = '0; d_wr_data = '0;
      mem_data_valid = 1'b0; mem_data_out = '0;
      step();
      step();
      chk("reset_outputs", 64'(w_outs), 64'(0));
      d_wr_req = 1'b1; d_wr_addr = 16'h0042; d_wr_data = 16'h1111;
      d_miss = 1'b1; i_miss = 1'b1;
      #1;
      chk("reset_outputs_req", 64'(w_outs), 64'(0));
      d_wr_req = 1'b0; d_miss = 1'b0; i_miss = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // single I fill at fixed latency
      step();
      t0 = cyc;
      i_miss = 1'b1; i_miss_addr = 16'h1236;
      push_fill(1'b0, 16'h1230, t0 + 1, t0 + 5);
      drain(60);

      // simultaneous D and I misses: D first, I right after done
      step();
      t0 = cyc;
      d_miss = 1'b1; d_miss_addr = 16'h2010;
      i_miss = 1'b1; i_miss_addr = 16'h3456;
      push_fill(1'b1, 16'h2010, t0 + 1, t0 + 5);
      push_fill(1'b0, 16'h3450, t0 + 14, t0 + 18);
      drain(80);

      // store wins over a pending D miss
      step();
      t0 = cyc;
      d_wr_req = 1'b1; d_wr_addr = 16'h00A4; d_wr_data = 16'hBEEF;
      d_miss = 1'b1; d_miss_addr = 16'h0A5E;
      mq.push_back('{1'b1, 16'h00A4, 16'hBEEF, t0});
      push_fill(1'b1, 16'h0A50, t0 + 2, t0 + 6);
      drain(60);

      // store raised mid-fill waits until after done
      step();
      t0 = cyc;
      i_miss = 1'b1; i_miss_addr = 16'h4000;
      push_fill(1'b0, 16'h4000, t0 + 1, t0 + 5);
      repeat (3) step();
      d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'h1234;
      mq.push_back('{1'b1, 16'h0100, 16'h1234, t0 + 13});
      drain(60);

      // reset at cycle 7 of a fill, returns still in flight
      step();
      t0 = cyc;
      i_miss = 1'b1; i_miss_addr = 16'h5008;
      for (int k = 0; k < 6; k++)
         mq.push_back('{1'b0, 16'(16'h5000 + 16'(2 * k)), 16'h0,
                        t0 + 1 + k});
      for (int k = 0; k < 2; k++)
         fq.push_back('{1'b0, k, memw(16'(16'h5000 + 16'(2 * k))),
                        1'b0, t0 + 5 + k});
      repeat (7) step();
      rst_n = 1'b0;
      i_miss = 1'b0;
      #1;
      chk("reset_mid_outputs", 64'(w_outs), 64'(0));
      repeat (3) step();
      rst_n = 1'b1;
      repeat (12) step();
      chk("reset_leftover", 64'(mq.size() + fq.size()), 64'(0));
      chk("reset_returns_gone", 64'(pq.size()), 64'(0));
      mq.delete();
      fq.delete();

      // non-uniform latency, in-order returns
      var_lat = 1'b1;
      li = 0;
      step();
      t0 = cyc;
      d_miss = 1'b1; d_miss_addr = 16'h7FFE;
      push_fill(1'b1, 16'h7FF0, t0 + 1, -1);
      drain(80);
      var_lat = 1'b0;

      // stray return while idle
      step();
      mem_data_valid = 1'b1;
      mem_data_out = 16'hDEAD;
      #1;
      chk("idle_valid_ignored", 64'(w_outs), 64'(0));
      step();
      step();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mem_miss_arbiter.md
Name: mem_miss_arbiter

Overview:
Arbitrates the single shared main-memory port between I-cache miss fills, D-cache miss fills and D-side write-through stores. Sequences each block fill: issues the word addresses back-to-back, collects the pipelined read returns and streams them into the requesting cache's data array. Sits between the cache pair and main memory. While a fill is in progress, the fetch and memory stages are held by the caches' miss signals.

Parameters:
BLOCK_WORDS, 8, 16-bit words per cache block (power of 2; block = 2*BLOCK_WORDS bytes).
MEM_LATENCY, 4, cycles from mem_enable to mem_data_valid for a read; informational only, since the arbiter counts returns and does not time them.
ADDR_W, 16, byte-address width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
i_miss  in  1  I-cache miss request; held high until i_fill_done.
i_miss_addr  in  ADDR_W  I-side miss byte address.
d_miss  in  1  D-cache miss request; held high until d_fill_done.
d_miss_addr  in  ADDR_W  D-side miss byte address.
d_wr_req  in  1  write-through store request.
d_wr_addr  in  ADDR_W  store byte address.
d_wr_data  in  16  store data.
d_wr_ack  out  1  one-cycle pulse; store issued to memory.
mem_enable  out  1  memory access strobe.
mem_wr  out  1  1 = write, 0 = read (valid when mem_enable).
mem_addr  out  ADDR_W  memory byte address.
mem_data_in  out  16  memory write data.
mem_data_valid  in  1  read data returned this cycle.
mem_data_out  in  16  read data.
fill_data  out  16  word to write into the cache array.
fill_word  out  log2(BLOCK_WORDS)  word index within the block.
i_fill_we  out  1  write fill_data into the I-cache array.
d_fill_we  out  1  write fill_data into the D-cache array.
i_fill_done  out  1  one-cycle pulse; I-cache writes its tag/valid bit.
d_fill_done  out  1  one-cycle pulse; D-cache writes its tag/valid bit.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all counters 0, every output 0.
- States: IDLE, FILL_I, FILL_D.
- IDLE priority, evaluated each cycle: d_wr_req > d_miss > i_miss.
- Store in IDLE: combinational mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1. State stays IDLE.
- Else d_miss: latch base = d_miss_addr with low log2(2*BLOCK_WORDS) bits cleared; go to FILL_D. Else i_miss: same, go to FILL_I.
- FILL_x issue phase: while issue_cnt < BLOCK_WORDS, drive mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt increments every cycle. No memory back-pressure.
- FILL_x return phase: on mem_data_valid, set fill_data=mem_data_out, fill_word=recv_cnt, assert the matching x_fill_we, and increment recv_cnt. Returns arrive in issue order.
- Last return (recv_cnt = BLOCK_WORDS-1 with valid): assert x_fill_done in the same cycle as the last x_fill_we. Next state IDLE; counters clear.
- Timing with MEM_LATENCY=4, BLOCK_WORDS=8: request sampled cycle 0; addresses issued cycles 1-8; data valid cycles 5-12; done pulse in cycle 12. A new grant is possible in cycle 13.
- d_wr_req during a fill: not acked; the request waits for IDLE.
- A lower-priority miss raised during a fill is served after the current fill, subject to the IDLE priority order.
- mem_data_valid in IDLE is ignored; no fill_we is asserted.
- Reset mid-fill: immediate return to IDLE. No done pulse. Late returns are ignored under the IDLE rule. The caches re-request after reset.
- Counters are log2(BLOCK_WORDS)+1 bits wide; no wrap occurs within a fill.
- Only one of i_fill_we/d_fill_we and at most one done pulse is active per cycle.

Decomposition:
- Shared package: state enum (IDLE, FILL_I, FILL_D), BLOCK_WORDS, offset-mask constant.
- One natural sub-module, fill_counter: issue/receive counter pair with a last-word flag, instantiated once.

Test Plan:
- i_miss=1, i_miss_addr=0x1236 -> mem_addr 0x1230, 0x1232 … 0x123E in cycles 1-8; i_fill_we with fill_word 0-7 in cycles 5-12; i_fill_done only in cycle 12.
- d_miss and i_miss raised in the same cycle -> D fill (FILL_D) completes first, then I fill starts in the cycle after d_fill_done.
- d_wr_req, d_wr_addr=0x00A4, d_wr_data=0xBEEF, with d_miss also high -> mem_wr=1, addr 0x00A4, data 0xBEEF, d_wr_ack in that cycle; D fill starts next cycle.
- d_wr_req asserted mid-fill -> no ack until the cycle after the done pulse; mem_wr never 1 during the fill.
- rst_n pulled low at cycle 7 of a fill, with memory still returning valids -> all outputs 0 immediately; no fill_we or done pulse afterwards.
- Memory model with non-uniform latency (2-6 cycles, in order) -> exactly 8 fill_we pulses with correct word indices and data; done coincides with word 7.
